// File: rtl/hdc_frame_bridge_pkg.sv
// Shared constants for the HDC frame bridge: status-word layout and sequence width.
// FRAME_STAMP_EN adds a fifth status word carrying a per-frame index.
package hdc_frame_bridge_pkg;

   localparam int DEF_WORD_WIDTH = 16;
   localparam int SEQ_WIDTH      = 8;

   localparam int DIST_IDX  = 0;
   localparam int LABEL_IDX = 1;
   localparam int CNTR_IDX  = 2;
   localparam int FLAGS_IDX = 3;
   localparam int STAMP_IDX = 4;

`ifdef FRAME_STAMP_EN
   localparam int STATUS_WORDS = 5;
`else
   localparam int STATUS_WORDS = 4;
`endif

   // The stale flag always sits in the MSB of the flags word.
   function automatic int stale_bit(input int word_width);
      return word_width - 1;
   endfunction

endpackage

// File: rtl/hdc_status_regs.sv
// Classifier result capture, sequence/freshness tracking and status-word assembly; 1-cycle capture.
// Results are accepted whenever reset is low. FRAME_STAMP_EN adds a frame index counter.
module hdc_status_regs
   import hdc_frame_bridge_pkg::*;
#(
   parameter int WORD_WIDTH     = DEF_WORD_WIDTH,
   parameter int LABEL_WIDTH    = 5,
   parameter int DISTANCE_WIDTH = 10,
   parameter int CNTR_WIDTH     = 8
) (
   input  logic                           Clk_CI,
   input  logic                           Reset_RI,
   input  logic                           accept,
   input  logic                           res_vld,
   output logic                           res_rdy,
   input  logic [LABEL_WIDTH-1:0]         res_label_dat,
   input  logic [DISTANCE_WIDTH-1:0]      res_dist_dat,
   input  logic [CNTR_WIDTH-1:0]          feature_cntr_dat,
   output logic [STATUS_WORDS*WORD_WIDTH-1:0] status_dat
);

   localparam int STALE_BIT = stale_bit(WORD_WIDTH);

   logic [LABEL_WIDTH-1:0]    label_q;
   logic [DISTANCE_WIDTH-1:0] dist_q;
   logic [SEQ_WIDTH-1:0]      seq_q;
   logic                      fresh_q;
   logic                      res_cap;
   logic [WORD_WIDTH-1:0]     flags_word;
`ifdef FRAME_STAMP_EN
   logic [WORD_WIDTH-1:0]     frame_idx_q;
`endif

   assign res_rdy = ~Reset_RI;
   assign res_cap = res_vld & res_rdy;

   always_ff @(posedge Clk_CI) begin
      if (Reset_RI) begin
         label_q <= '0;
         dist_q  <= '0;
         seq_q   <= '0;
         fresh_q <= 1'b0;
      end else begin
         if (res_cap) begin
            label_q <= res_label_dat;
            dist_q  <= res_dist_dat;
            seq_q   <= seq_q + 1'b1;
         end
         // A result landing with a frame wins: that frame reports the old
         // snapshot, so the new result must still be fresh for the next one.
         if (res_cap)
            fresh_q <= 1'b1;
         else if (accept)
            fresh_q <= 1'b0;
      end
   end

`ifdef FRAME_STAMP_EN
   always_ff @(posedge Clk_CI) begin
      if (Reset_RI)
         frame_idx_q <= '0;
      else if (accept)
         frame_idx_q <= frame_idx_q + 1'b1;
   end
`endif

   always_comb begin
      flags_word                  = '0;
      flags_word[STALE_BIT]       = ~fresh_q;
      flags_word[SEQ_WIDTH-1:0]   = seq_q;

      status_dat = '0;
      status_dat[DIST_IDX*WORD_WIDTH  +: WORD_WIDTH] = WORD_WIDTH'(dist_q);
      status_dat[LABEL_IDX*WORD_WIDTH +: WORD_WIDTH] = WORD_WIDTH'(label_q);
      status_dat[CNTR_IDX*WORD_WIDTH  +: WORD_WIDTH] = WORD_WIDTH'(feature_cntr_dat);
      status_dat[FLAGS_IDX*WORD_WIDTH +: WORD_WIDTH] = flags_word;
`ifdef FRAME_STAMP_EN
      status_dat[STAMP_IDX*WORD_WIDTH +: WORD_WIDTH] = frame_idx_q;
`endif
   end

endmodule

// File: rtl/hdc_frame_bridge.sv
// Forks each ADC frame to the encoder path and a status-stamped loop-back path; 1-cycle latency.
// A frame is taken only when both one-entry slots can accept; slots drain independently (FRAME_STAMP_EN optional).
module hdc_frame_bridge
   import hdc_frame_bridge_pkg::*;
#(
   parameter int NUM_WORDS      = 64,
   parameter int WORD_WIDTH     = DEF_WORD_WIDTH,
   parameter int NUM_CHANNELS   = 60,
   parameter int RAW_WIDTH      = 15,
   parameter int MODE_WIDTH     = 2,
   parameter int LABEL_WIDTH    = 5,
   parameter int DISTANCE_WIDTH = 10,
   parameter int CNTR_WIDTH     = 8
) (
   input  logic                              Clk_CI,
   input  logic                              Reset_RI,
   input  logic                              FrameValid_SI,
   output logic                              FrameReady_SO,
   input  logic [NUM_WORDS*WORD_WIDTH-1:0]   FrameIn_DI,
   input  logic [MODE_WIDTH-1:0]             ModeIn_SI,
   input  logic [LABEL_WIDTH-1:0]            LabelIn_DI,
   output logic                              EncValid_SO,
   input  logic                              EncReady_SI,
   output logic [NUM_CHANNELS*RAW_WIDTH-1:0] EncRaw_DO,
   output logic [MODE_WIDTH-1:0]             EncMode_SO,
   output logic [LABEL_WIDTH-1:0]            EncLabel_DO,
   input  logic                              ResValid_SI,
   output logic                              ResReady_SO,
   input  logic [LABEL_WIDTH-1:0]            ResLabel_DI,
   input  logic [DISTANCE_WIDTH-1:0]         ResDistance_DI,
   input  logic [CNTR_WIDTH-1:0]             FeatureCntr_DI,
   output logic                              OutValid_SO,
   input  logic                              OutReady_SI,
   output logic [NUM_WORDS*WORD_WIDTH-1:0]   OutFrame_DO
);

   logic                                 accept;
   logic [STATUS_WORDS*WORD_WIDTH-1:0]   status_dat;
   logic [NUM_CHANNELS*RAW_WIDTH-1:0]    enc_raw_nxt;
   logic [NUM_WORDS*WORD_WIDTH-1:0]      out_frame_nxt;

   assign FrameReady_SO = ~Reset_RI
                        & (~EncValid_SO | EncReady_SI)
                        & (~OutValid_SO | OutReady_SI);
   assign accept = FrameValid_SI & FrameReady_SO;

   hdc_status_regs #(
      .WORD_WIDTH     (WORD_WIDTH),
      .LABEL_WIDTH    (LABEL_WIDTH),
      .DISTANCE_WIDTH (DISTANCE_WIDTH),
      .CNTR_WIDTH     (CNTR_WIDTH)
   ) u_status_regs (
      .Clk_CI           (Clk_CI),
      .Reset_RI         (Reset_RI),
      .accept           (accept),
      .res_vld          (ResValid_SI),
      .res_rdy          (ResReady_SO),
      .res_label_dat    (ResLabel_DI),
      .res_dist_dat     (ResDistance_DI),
      .feature_cntr_dat (FeatureCntr_DI),
      .status_dat       (status_dat)
   );

   always_comb begin
      enc_raw_nxt = '0;
      for (int j = 0; j < NUM_CHANNELS; j++)
         enc_raw_nxt[j*RAW_WIDTH +: RAW_WIDTH] = FrameIn_DI[j*WORD_WIDTH +: RAW_WIDTH];
   end

   // Status words overlay the low end of the frame; the rest passes through.
   always_comb begin
      out_frame_nxt = FrameIn_DI;
      out_frame_nxt[STATUS_WORDS*WORD_WIDTH-1:0] = status_dat;
   end

   always_ff @(posedge Clk_CI) begin
      if (Reset_RI) begin
         EncValid_SO <= 1'b0;
         EncRaw_DO   <= '0;
         EncMode_SO  <= '0;
         EncLabel_DO <= '0;
      end else if (accept) begin
         EncValid_SO <= 1'b1;
         EncRaw_DO   <= enc_raw_nxt;
         EncMode_SO  <= ModeIn_SI;
         EncLabel_DO <= LabelIn_DI;
      end else if (EncReady_SI) begin
         EncValid_SO <= 1'b0;
      end
   end

   always_ff @(posedge Clk_CI) begin
      if (Reset_RI) begin
         OutValid_SO <= 1'b0;
         OutFrame_DO <= '0;
      end else if (accept) begin
         OutValid_SO <= 1'b1;
         OutFrame_DO <= out_frame_nxt;
      end else if (OutReady_SI) begin
         OutValid_SO <= 1'b0;
      end
   end

endmodule

// File: tb/tb_hdc_frame_bridge.sv
// Directed bench for hdc_frame_bridge: fork handshakes, status words, freshness, sequence wrap, reset.
// Honours FRAME_STAMP_EN when the design is built with it.
module tb_hdc_frame_bridge;

   localparam int NW = 64;
   localparam int WW = 16;
   localparam int NC = 60;
   localparam int RW = 15;

   logic                Clk_CI = 1'b0;
   logic                Reset_RI;
   logic                FrameValid_SI;
   logic                FrameReady_SO;
   logic [NW*WW-1:0]    FrameIn_DI;
   logic [1:0]          ModeIn_SI;
   logic [4:0]          LabelIn_DI;
   logic                EncValid_SO;
   logic                EncReady_SI;
   logic [NC*RW-1:0]    EncRaw_DO;
   logic [1:0]          EncMode_SO;
   logic [4:0]          EncLabel_DO;
   logic                ResValid_SI;
   logic                ResReady_SO;
   logic [4:0]          ResLabel_DI;
   logic [9:0]          ResDistance_DI;
   logic [7:0]          FeatureCntr_DI;
   logic                OutValid_SO;
   logic                OutReady_SI;
   logic [NW*WW-1:0]    OutFrame_DO;

   int checks   = 0;
   int failures = 0;

   hdc_frame_bridge dut (
      .Clk_CI         (Clk_CI),
      .Reset_RI       (Reset_RI),
      .FrameValid_SI  (FrameValid_SI),
      .FrameReady_SO  (FrameReady_SO),
      .FrameIn_DI     (FrameIn_DI),
      .ModeIn_SI      (ModeIn_SI),
      .LabelIn_DI     (LabelIn_DI),
      .EncValid_SO    (EncValid_SO),
      .EncReady_SI    (EncReady_SI),
      .EncRaw_DO      (EncRaw_DO),
      .EncMode_SO     (EncMode_SO),
      .EncLabel_DO    (EncLabel_DO),
      .ResValid_SI    (ResValid_SI),
      .ResReady_SO    (ResReady_SO),
      .ResLabel_DI    (ResLabel_DI),
      .ResDistance_DI (ResDistance_DI),
      .FeatureCntr_DI (FeatureCntr_DI),
      .OutValid_SO    (OutValid_SO),
      .OutReady_SI    (OutReady_SI),
      .OutFrame_DO    (OutFrame_DO)
   );

   always #5 Clk_CI = ~Clk_CI;

   function automatic logic [NW*WW-1:0] mk_frame(input logic [15:0] base);
      logic [NW*WW-1:0] f;
      for (int k = 0; k < NW; k++) f[k*WW +: WW] = base + 16'(k);
      return f;
   endfunction

   function automatic logic [31:0] out_word(input int k);
      return 32'(OutFrame_DO[k*WW +: WW]);
   endfunction

   function automatic logic [31:0] enc_ch(input int j);
      return 32'(EncRaw_DO[j*RW +: RW]);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge; inputs then change and outputs are sampled 1 ns later.
   task automatic tick();
      @(posedge Clk_CI);
      #1;
   endtask

   logic [31:0] held_w10;

   initial begin
      Reset_RI = 1'b1; FrameValid_SI = 1'b0; FrameIn_DI = '0;
      ModeIn_SI = '0; LabelIn_DI = '0; EncReady_SI = 1'b1; OutReady_SI = 1'b1;
      ResValid_SI = 1'b0; ResLabel_DI = '0; ResDistance_DI = '0; FeatureCntr_DI = '0;
      tick(); tick();
      chk("rst_frame_ready", 32'(FrameReady_SO), 32'h0);
      chk("rst_res_ready",   32'(ResReady_SO),   32'h0);
      Reset_RI = 1'b0;
      tick();
      chk("idle_enc_valid",   32'(EncValid_SO),   32'h0);
      chk("idle_out_valid",   32'(OutValid_SO),   32'h0);
      chk("idle_out_frame",   32'(OutFrame_DO == '0), 32'h1);
      chk("idle_enc_raw",     32'(EncRaw_DO == '0),   32'h1);
      chk("idle_res_ready",   32'(ResReady_SO),   32'h1);
      chk("idle_frame_ready", 32'(FrameReady_SO), 32'h1);

      // First frame: stale, seq 0
      FrameIn_DI = mk_frame(16'h0100); FrameValid_SI = 1'b1;
      ModeIn_SI = 2'd2; LabelIn_DI = 5'd3; FeatureCntr_DI = 8'h2A;
      tick();
      FrameValid_SI = 1'b0;
      chk("f1_enc_valid", 32'(EncValid_SO), 32'h1);
      chk("f1_out_valid", 32'(OutValid_SO), 32'h1);
      chk("f1_ch0",  enc_ch(0),  32'h0100);
      chk("f1_ch59", enc_ch(59), 32'h013B);
      chk("f1_mode",  32'(EncMode_SO),  32'h2);
      chk("f1_label", 32'(EncLabel_DO), 32'h3);
      chk("f1_w0",  out_word(0),  32'h0000);
      chk("f1_w2",  out_word(2),  32'h002A);
      chk("f1_w3",  out_word(3),  32'h8000);
`ifdef FRAME_STAMP_EN
      chk("f1_w4",  out_word(4),  32'h0000);
`else
      chk("f1_w4",  out_word(4),  32'h0104);
`endif
      chk("f1_w63", out_word(63), 32'h013F);
      tick();
      chk("f1_drained_enc", 32'(EncValid_SO), 32'h0);
      chk("f1_drained_out", 32'(OutValid_SO), 32'h0);

      // Result, then two frames: fresh then stale
      ResValid_SI = 1'b1; ResLabel_DI = 5'd7; ResDistance_DI = 10'h155;
      tick();
      ResValid_SI = 1'b0;
      FrameIn_DI = mk_frame(16'h0200); FrameValid_SI = 1'b1;
      tick();
      chk("f2_w0", out_word(0), 32'h0155);
      chk("f2_w1", out_word(1), 32'h0007);
      chk("f2_w3", out_word(3), 32'h0001);
      tick();
      FrameValid_SI = 1'b0;
      chk("f3_w3", out_word(3), 32'h8001);
      chk("f3_w5", out_word(5), 32'h0205);
      tick();

      // Return branch stalled: second frame must wait, output must hold
      OutReady_SI = 1'b0;
      FrameIn_DI = mk_frame(16'h0300); FrameValid_SI = 1'b1;
      tick();
      FrameIn_DI = mk_frame(16'h0400);
      chk("bp_frame_ready_lo", 32'(FrameReady_SO), 32'h0);
      held_w10 = out_word(10);
      chk("bp_w10_first", held_w10, 32'h030A);
      tick();
      chk("bp_enc_drained", 32'(EncValid_SO), 32'h0);
      chk("bp_out_held",    32'(OutValid_SO), 32'h1);
      chk("bp_w10_stable1", out_word(10), 32'h030A);
      tick();
      chk("bp_w10_stable2", out_word(10), 32'h030A);
      chk("bp_still_blocked", 32'(FrameReady_SO), 32'h0);
      OutReady_SI = 1'b1;
      #1;
      chk("bp_frame_ready_hi", 32'(FrameReady_SO), 32'h1);
      tick();
      FrameValid_SI = 1'b0;
      chk("bp_w10_second", out_word(10), 32'h040A);
      chk("bp_enc_reload", 32'(EncValid_SO), 32'h1);
      chk("bp_ch10", enc_ch(10), 32'h040A);
      tick();

      // Result in the same cycle as accept
      ResValid_SI = 1'b1; ResLabel_DI = 5'd9; ResDistance_DI = 10'h2AA;
      FrameIn_DI = mk_frame(16'h0500); FrameValid_SI = 1'b1;
      tick();
      ResValid_SI = 1'b0;
      chk("sc_old_w0", out_word(0), 32'h0155);
      chk("sc_old_w1", out_word(1), 32'h0007);
      chk("sc_old_w3", out_word(3), 32'h8001);
      tick();
      FrameValid_SI = 1'b0;
      chk("sc_new_w0", out_word(0), 32'h02AA);
      chk("sc_new_w1", out_word(1), 32'h0009);
      chk("sc_new_w3", out_word(3), 32'h0002);
      tick();

      // 254 more results take seq from 2 through 255 to 0
      ResValid_SI = 1'b1; ResLabel_DI = 5'd17; ResDistance_DI = 10'h3FF;
      repeat (253) tick();
      ResValid_SI = 1'b0;
      FrameIn_DI = mk_frame(16'h0600); FrameValid_SI = 1'b1;
      tick();
      chk("seq_255", out_word(3), 32'h00FF);
      FrameValid_SI = 1'b0;
      ResValid_SI = 1'b1;
      tick();
      ResValid_SI = 1'b0;
      FrameValid_SI = 1'b1;
      tick();
      FrameValid_SI = 1'b0;
      chk("seq_wrap", out_word(3), 32'h0000);
      chk("seq_dist", out_word(0), 32'h03FF);
      chk("seq_label", out_word(1), 32'h0011);
      tick();

      // Reset with both slots full and stalled
      EncReady_SI = 1'b0; OutReady_SI = 1'b0;
      FrameIn_DI = mk_frame(16'h0700); FrameValid_SI = 1'b1;
      tick();
      FrameValid_SI = 1'b0;
      chk("pre_rst_enc_valid", 32'(EncValid_SO), 32'h1);
      chk("pre_rst_out_valid", 32'(OutValid_SO), 32'h1);
      Reset_RI = 1'b1;
      tick();
      chk("mid_rst_enc_valid", 32'(EncValid_SO), 32'h0);
      chk("mid_rst_out_valid", 32'(OutValid_SO), 32'h0);
      chk("mid_rst_out_frame", 32'(OutFrame_DO == '0), 32'h1);
      Reset_RI = 1'b0;
      EncReady_SI = 1'b1; OutReady_SI = 1'b1;

      // Three back-to-back frames after reset
      FrameIn_DI = mk_frame(16'h0800); FrameValid_SI = 1'b1;
      for (int n = 0; n < 3; n++) begin
         tick();
         chk("post_rst_w3", out_word(3), 32'h8000);
`ifdef FRAME_STAMP_EN
         chk("stamp_w4", out_word(4), 32'(n));
`else
         chk("pass_w4", out_word(4), 32'h0804);
`endif
      end
      FrameValid_SI = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hdc_frame_bridge.md
Name: hdc_frame_bridge

Overview:
Parametrised bridge between the ADC frame FIFO and the HDC classifier pipeline. Each accepted raw frame is forked to two paths:
- the encoder path, as channel-mapped raw samples;
- a return path, as a loop-back frame whose low words are overwritten by classifier status.

The bridge captures classifier results and tracks result freshness and sequence. It generalises the fixed 64x16 frame / 60-channel mapping to arbitrary geometry and adds proper back-pressure on both fork branches.

Parameters:
NUM_WORDS, 64, words per frame
WORD_WIDTH, 16, bits per frame word
NUM_CHANNELS, 60, channels mapped to encoder (NUM_CHANNELS <= NUM_WORDS)
RAW_WIDTH, 15, bits kept per channel (low bits of word; RAW_WIDTH <= WORD_WIDTH)
MODE_WIDTH, 2, mode field width
LABEL_WIDTH, 5, label width (<= WORD_WIDTH)
DISTANCE_WIDTH, 10, distance width (<= WORD_WIDTH)
CNTR_WIDTH, 8, feature counter width (<= WORD_WIDTH)

Ports:
Clk_CI  in  1  clock
Reset_RI  in  1  synchronous reset, active high
FrameValid_SI  in  1  input frame valid
FrameReady_SO  out  1  input frame ready
FrameIn_DI  in  NUM_WORDS*WORD_WIDTH  raw frame; word k = bits [(k+1)*WORD_WIDTH-1 : k*WORD_WIDTH]
ModeIn_SI  in  MODE_WIDTH  mode, sampled with frame
LabelIn_DI  in  LABEL_WIDTH  training label, sampled with frame
EncValid_SO  out  1  encoder-path valid
EncReady_SI  in  1  encoder-path ready
EncRaw_DO  out  NUM_CHANNELS*RAW_WIDTH  channel j = word j bits [RAW_WIDTH-1:0]
EncMode_SO  out  MODE_WIDTH  registered mode
EncLabel_DO  out  LABEL_WIDTH  registered label
ResValid_SI  in  1  classifier result valid
ResReady_SO  out  1  result ready
ResLabel_DI  in  LABEL_WIDTH  classified label
ResDistance_DI  in  DISTANCE_WIDTH  Hamming distance
FeatureCntr_DI  in  CNTR_WIDTH  feature-window counter (debug)
OutValid_SO  out  1  loop-back frame valid
OutReady_SI  in  1  loop-back frame ready
OutFrame_DO  out  NUM_WORDS*WORD_WIDTH  frame with status words

Behaviour:
Reset:
- Clock is Clk_CI; reset Reset_RI is synchronous and active high.
- While reset is asserted, all registers clear: EncValid_SO=0, OutValid_SO=0, all data outputs 0, LabelReg=0, DistReg=0, ResSeq=0, Fresh=0.
- ResReady_SO = ~Reset_RI (combinational). FrameReady_SO=0 during reset.
- Reset mid-transfer discards both slots without completing any handshake.

Encoder and return slots:
- Each is a one-entry register with a full flag (EncValid_SO / OutValid_SO).
- FrameReady_SO = (~EncValid_SO | EncReady_SI) & (~OutValid_SO | OutReady_SI). This is combinational from the ready inputs.
- Accept = FrameValid_SI & FrameReady_SO. On accept, both slots load on the same edge, giving 1-cycle latency. Throughput is one frame/cycle when both branches are ready.
- A slot drains on its own valid&ready; the branches drain independently.
- A drain and a reload in the same cycle keep valid=1 with the new data.
- Outputs are stable while valid & ~ready.

Result capture:
- On ResValid_SI & ResReady_SO: LabelReg, DistReg load; ResSeq increments mod 256 (255 -> 0); Fresh <= 1.

Status words (snapshot of pre-edge register values on accept):
- word0 = zero-extended DistReg
- word1 = zero-extended LabelReg
- word2 = zero-extended FeatureCntr_DI
- word3 = {Stale, zeros, ResSeq[7:0]}, where Stale = ~Fresh. Bit WORD_WIDTH-1 carries Stale; bits [7:0] carry ResSeq. This needs WORD_WIDTH >= 9.
- All words >= STATUS_WORDS copy FrameIn_DI unchanged. STATUS_WORDS = 4, or 5 with FRAME_STAMP_EN.

Fresh update on accept:
- On accept, Fresh <= 0, unless a result is captured in the same cycle; then Fresh <= 1.
- A same-cycle result is not visible in that frame's status; it appears in the next frame.

Optional Feature:
FRAME_STAMP_EN:
- Defined: adds a WORD_WIDTH-bit FrameIdx counter that increments on every accept and wraps. Word4 = FrameIdx value before increment, so the first frame carries 0. STATUS_WORDS=5.
- Undefined: no counter; word4 passes through; STATUS_WORDS=4.

Decomposition:
- Shared constants package/header: WORD_WIDTH, STATUS_WORDS, status word indices (DIST_IDX=0, LABEL_IDX=1, CNTR_IDX=2, FLAGS_IDX=3, STAMP_IDX=4), STALE_BIT, SEQ_WIDTH=8.
- One sub-module: hdc_status_regs, holding result capture, ResSeq/Fresh and the status-word assembly. Slot logic stays in the top.

Test Plan:
- Reset, then idle: all outputs 0; ResReady_SO=1; FrameReady_SO=1. Push a frame with word k = k+0x100 -> one cycle later EncValid_SO=OutValid_SO=1; channel j = (j+0x100)&0x7FFF; word3 = 0x8000 (stale, seq 0); word63 = 0x13F.
- Result label=7, dist=0x155, then a frame -> word0=0x155, word1=7, word3=0x0001. The next frame with no new result -> word3=0x8001.
- OutReady_SI=0, EncReady_SI=1, two frames offered -> first accepted; second blocked (FrameReady_SO=0) until OutReady_SI rises; OutFrame_DO stays stable meanwhile.
- Result valid in the same cycle as accept -> that frame shows old values; the next frame shows new values with Stale=0.
- 256 results -> ResSeq wraps to 0x00.
- Reset asserted while both slots are full and ready is low -> next cycle EncValid_SO=OutValid_SO=0; no handshake observed. With FRAME_STAMP_EN: word4 = 0,1,2 across three frames.
